// File: rtl/spi_pkg.sv
// spi_pkg: shared widths, FSM encoding and command record for spi_txn_arbiter
package spi_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int FREQ_W = 10;
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LAUNCH    = 3'd1;
  localparam logic [2:0] ST_WAIT_LOW  = 3'd2;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd3;
  localparam logic [2:0] ST_RESP      = 3'd4;
  localparam logic [2:0] ST_GAP       = 3'd5;
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [FREQ_W-1:0] freq;
  } cmd_t;
endpackage

// File: rtl/spi_txn_arbiter_if.sv
// spi_txn_arbiter_if: client request bus plus spi_master command/status signals
interface spi_txn_arbiter_if import spi_pkg::*; #(parameter int NUM_REQ = 2);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_wr;
  logic [ADDR_W*NUM_REQ-1:0] req_addr;
  logic [DATA_W*NUM_REQ-1:0] req_wdata;
  logic [FREQ_W*NUM_REQ-1:0] req_freq;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      busy;
  logic                      spi_start_wr;
  logic                      spi_start_re;
  logic [ADDR_W-1:0]         spi_addr;
  logic [DATA_W-1:0]         spi_wdata;
  logic [FREQ_W-1:0]         spi_freq;
  logic [DATA_W-1:0]         spi_rdata;
  logic                      spi_ss;
`ifdef SPI_ARB_TIMEOUT_EN
  logic                      err;
`endif
  modport slave (
    input  req, req_wr, req_addr, req_wdata, req_freq, spi_rdata, spi_ss,
    output
`ifdef SPI_ARB_TIMEOUT_EN
    err,
`endif
    ack, rsp_rdata, busy, spi_start_wr, spi_start_re, spi_addr, spi_wdata, spi_freq
  );
  modport master (
    output req, req_wr, req_addr, req_wdata, req_freq, spi_rdata, spi_ss,
    input
`ifdef SPI_ARB_TIMEOUT_EN
    err,
`endif
    ack, rsp_rdata, busy, spi_start_wr, spi_start_re, spi_addr, spi_wdata, spi_freq
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant of the first set request at or above ptr_i, wrapping
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o
);
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0] j;
  // walk offsets from farthest to nearest so the nearest set request wins
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    j = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = IW'((int'(ptr_i) + k) % NUM_REQ);
      if (req_i[j]) begin
        gnt_o = '0;
        gnt_o[j] = 1'b1;
        idx_o = j;
      end
    end
  end
endmodule

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin sequencer sharing one spi_master; SPI_ARB_TIMEOUT_EN adds start timeout + err
module spi_txn_arbiter import spi_pkg::*; #(
  parameter int NUM_REQ       = 2,
  parameter int GAP_CYCLES    = 2,
  parameter int START_TIMEOUT = 16
) (
  input logic clock,
  input logic reset,
  spi_txn_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
  if (NUM_REQ < 2 || NUM_REQ > 8 || START_TIMEOUT < 1 || GAP_CYCLES < 0) begin : g_bad_cfg
    $error("spi_txn_arbiter: unsupported parameter set");
  end
  logic [2:0]         state_q, state_d;
  cmd_t               cmd_q, cmd_d, win_cmd;
  logic [IW-1:0]      idx_q, idx_d, rr_q, rr_d, win_idx;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, win_gnt;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [GW-1:0]      gap_q, gap_d;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(START_TIMEOUT + 1);
  logic [TW-1:0]      to_q, to_d;
  logic               err_q, err_d;
  assign bus.err = err_q;
`endif
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i(bus.req),
    .ptr_i(rr_q),
    .gnt_o(win_gnt),
    .idx_o(win_idx)
  );
  assign win_cmd = '{
    wr:    bus.req_wr[win_idx],
    addr:  bus.req_addr[int'(win_idx)*ADDR_W +: ADDR_W],
    wdata: bus.req_wdata[int'(win_idx)*DATA_W +: DATA_W],
    freq:  bus.req_freq[int'(win_idx)*FREQ_W +: FREQ_W]
  };
  assign bus.busy         = state_q != ST_IDLE;
  assign bus.spi_start_wr = state_q == ST_LAUNCH && cmd_q.wr;
  assign bus.spi_start_re = state_q == ST_LAUNCH && !cmd_q.wr;
  assign bus.ack          = state_q == ST_RESP ? gnt_q : '0;
  assign bus.spi_addr     = cmd_q.addr;
  assign bus.spi_wdata    = cmd_q.wdata;
  assign bus.spi_freq     = cmd_q.freq;
  assign bus.rsp_rdata    = rdata_q;
  // transaction sequencing: arbitrate only in IDLE, follow ss through the frame, ack, then hold off
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    rdata_d = rdata_q;
    gap_d   = gap_q;
`ifdef SPI_ARB_TIMEOUT_EN
    to_d    = to_q;
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: if (|bus.req) begin
        state_d = ST_LAUNCH;
        cmd_d   = win_cmd;
        idx_d   = win_idx;
        gnt_d   = win_gnt;
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT_LOW;
`ifdef SPI_ARB_TIMEOUT_EN
        to_d    = '0;
`endif
      end
      ST_WAIT_LOW: if (!bus.spi_ss) state_d = ST_WAIT_HIGH;
`ifdef SPI_ARB_TIMEOUT_EN
      else if (to_q == TW'(START_TIMEOUT - 1)) begin
        err_d   = 1'b1;
        rdata_d = '0;
        state_d = ST_RESP;
      end else to_d = to_q + 1'b1;
`endif
      ST_WAIT_HIGH: if (bus.spi_ss) begin
        rdata_d = bus.spi_rdata;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rr_d    = idx_q == IW'(NUM_REQ - 1) ? '0 : idx_q + 1'b1;
        gap_d   = GW'(GAP_CYCLES);
        state_d = GAP_CYCLES == 0 ? ST_IDLE : ST_GAP;
      end
      ST_GAP: begin
        gap_d   = gap_q == '0 ? '0 : gap_q - 1'b1;
        state_d = gap_q <= GW'(1) ? ST_IDLE : ST_GAP;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  // state and command registers; reset aborts any frame without an ack
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      rr_q    <= '0;
      rdata_q <= '0;
      gap_q   <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      to_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      rdata_q <= rdata_d;
      gap_q   <= gap_d;
`ifdef SPI_ARB_TIMEOUT_EN
      to_q    <= to_d;
      err_q   <= err_d;
`endif
    end
endmodule

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one spi_master between NUM_REQ requesters.
- Latches the winning requester's command, issues a one-cycle start_wr/start_re pulse to spi_master, and tracks the transaction through ss.
- On completion it returns rdata and a one-cycle ack to the winner.
- Sits between client logic and spi_master; spi_slave and piso are unchanged.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- GAP_CYCLES, 2, idle cycles enforced between the end of one transaction and the next arbitration.
- START_TIMEOUT, 16, cycles allowed for ss to go low after a start pulse.

Ports:
- clock  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  level request per requester; held until its ack.
- req_wr  in  NUM_REQ  per requester: 1 = write, 0 = read.
- req_addr  in  8*NUM_REQ  packed per-requester address, requester i at [8i+7:8i].
- req_wdata  in  8*NUM_REQ  packed per-requester write data.
- req_freq  in  10*NUM_REQ  packed per-requester sclk divider value.
- ack  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- rsp_rdata  out  8  read data; valid in the ack cycle and held until the next ack.
- busy  out  1  high from grant until the end of GAP.
- spi_start_wr  out  1  to spi_master start_wr.
- spi_start_re  out  1  to spi_master start_re.
- spi_addr  out  8  to spi_master addr; registered.
- spi_wdata  out  8  to spi_master wdata; registered.
- spi_freq  out  10  to spi_master freq; registered.
- spi_rdata  in  8  from spi_master rdata.
- spi_ss  in  1  from spi_master ss; active-low frame.
- err  out  1  sticky timeout flag; exists only with the optional feature.

Behaviour:
- Reset: all outputs 0; state IDLE; rr pointer 0; gap counter 0.
- Shared values: state encoding is IDLE, LAUNCH, WAIT_LOW, WAIT_HIGH, RESP, GAP.
- IDLE
  - If any req bit is set, grant the first set bit searching from the rr pointer upward, wrapping modulo NUM_REQ.
  - Register the granted requester's wr/addr/wdata/freq onto spi_* and record grant_idx.
  - busy goes to 1 and the state moves to LAUNCH.
- LAUNCH
  - Assert exactly one of spi_start_wr (if wr) or spi_start_re for exactly one cycle, then go to WAIT_LOW.
  - spi_addr, spi_wdata and spi_freq stay stable from LAUNCH until leaving WAIT_HIGH.
- WAIT_LOW: wait for spi_ss == 0, then go to WAIT_HIGH.
- WAIT_HIGH
  - When spi_ss returns to 1, capture spi_rdata into rsp_rdata and go to RESP.
  - Read results are captured the same way as write results.
- RESP
  - ack[grant_idx] = 1 for this one cycle.
  - rr pointer becomes (grant_idx+1) mod NUM_REQ.
  - Load the gap counter and go to GAP.
- GAP
  - Count GAP_CYCLES cycles, then busy = 0 and go to IDLE.
  - With GAP_CYCLES = 0, go from RESP straight to IDLE.
- Latency: request seen in IDLE -> start pulse 1 cycle later (in LAUNCH). ack comes 1 cycle after ss rises.
- Request handling:
  - A requester dropping req after its grant does not abort the transaction; it still receives ack.
  - Requests arriving during a transaction wait. Only IDLE arbitrates, so a simultaneous req and ack from the same requester is ignored until IDLE.
- Fairness: a requester holding req continuously is served within NUM_REQ transactions.
- Reset mid-transaction
  - All state clears immediately and no ack is issued.
  - spi_master shares the same reset source, so no frame is left open.
- Width: the gap counter is clog2(GAP_CYCLES+1) bits and the timeout counter is clog2(START_TIMEOUT+1) bits, both saturating.

Optional Feature:
- SPI_ARB_TIMEOUT_EN defined:
  - In WAIT_LOW, if ss stays high for START_TIMEOUT cycles, set err (sticky until reset), force rsp_rdata = 8'h00 and go to RESP.
  - The requester is still acked, so clients never hang.
- Not defined: the err port is absent and WAIT_LOW waits indefinitely.

Decomposition:
- Package spi_pkg holds the state encoding localparams and the widths ADDR_W = 8, DATA_W = 8, FREQ_W = 10.
- One sub-module, rr_arbiter: combinational one-hot grant from the req vector and the rr pointer.
- The FSM, command registers and counters stay in spi_txn_arbiter.

Test Plan:
- Single read: req = 01, req_wr = 0, addr 8'h10, freq 100; slave model returns 8'h55 -> one spi_start_re pulse, then ack = 01 one cycle after ss rises, with rsp_rdata = 8'h55.
- Single write: req = 10, wr = 1, addr 8'h20, wdata 8'hA5 -> one spi_start_wr pulse; spi_wdata = 8'hA5 stable through the frame; ack = 10.
- Contention: req = 11 held asserted, 4 transactions -> grant order 0, 1, 0, 1. Each pair of adjacent frames is separated by at least GAP_CYCLES idle cycles with busy = 0 for at least 1 cycle.
- Mid-transaction reset: assert reset in WAIT_HIGH -> all outputs 0 next edge, no ack; a fresh req afterwards is granted starting from pointer 0.
- Timeout (SPI_ARB_TIMEOUT_EN): hold spi_ss = 1 after launch -> after 16 cycles err = 1, ack pulses, rsp_rdata = 8'h00; err remains 1 through the next good transaction.
- Drop req after grant: deassert req[0] in WAIT_LOW -> the transaction completes and ack[0] still pulses.
